// File: rtl/dmem_waitstate_responder_if.sv
// rtl/dmem_waitstate_responder_if.sv - load/store request/response bundle between core and data memory
interface dmem_waitstate_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] rdata;
    logic        err;
    logic        done;
    logic [31:0] done_value;

    // Core side: issues requests, observes responses and completion sentinel
    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ready,
        input  rdata,
        input  err,
        input  done,
        input  done_value
    );

    // Memory side: accepts requests, produces responses and completion sentinel
    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ready,
        output rdata,
        output err,
        output done,
        output done_value
    );
endinterface

// File: rtl/dmem_waitstate_responder.sv
// rtl/dmem_waitstate_responder.sv - word-addressed data memory answering one request after fixed wait states
module dmem_waitstate_responder #(
    parameter int          DEPTH     = 64,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] DONE_ADDR = 32'h64
) (
    input  logic                         clk,
    input  logic                         reset,
    dmem_waitstate_responder_if.slave    bus
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
    // The request is accepted on edge N and RESP is entered on edge N+LATENCY;
    // the BUSY count runs LATENCY-1 down to 0 so every latency shares one path.
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  cnt;
    logic [3:0]  cnt_n;

    logic        capture;
    logic        cap_we;
    logic        cap_legal;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic        req_legal;
    logic [AW-1:0] cap_idx;

    logic        ready_n;
    logic        err_n;
    logic [31:0] rdata_n;
    logic        commit;

    logic [31:0] ram [DEPTH];

    // Misaligned or beyond-the-array byte addresses are rejected; no aliasing of high bits
    assign req_legal = (bus.addr[1:0] == 2'b00) && (bus.addr[31:2] < DEPTH_W);
    assign cap_idx   = cap_addr[AW+1:2];

    // Next state, wait counter, response values and store commit
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        capture = 1'b0;
        ready_n = 1'b0;
        err_n   = 1'b0;
        rdata_n = 32'h0;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    capture = 1'b1;
                    cnt_n   = CNT_INIT;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    state_n = RESP;
                    ready_n = 1'b1;
                    err_n   = ~cap_legal;
                    commit  = cap_we & cap_legal;
                    if (!cap_we && cap_legal) begin
                        rdata_n = ram[cap_idx];
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            RESP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and wait counter; reset aborts any transaction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request capture; later changes on the bus are ignored until the next IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_we    <= 1'b0;
            cap_legal <= 1'b0;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
        end else if (capture) begin
            cap_we    <= bus.we;
            cap_legal <= req_legal;
            cap_addr  <= bus.addr;
            cap_wdata <= bus.wdata;
        end
    end

    // Registered response: high only during RESP, zero otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.ready <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'h0;
        end else begin
            bus.ready <= ready_n;
            bus.err   <= err_n;
            bus.rdata <= rdata_n;
        end
    end

    // Completion sentinel: sticky flag plus data of the latest legal write to DONE_ADDR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.done       <= 1'b0;
            bus.done_value <= 32'h0;
        end else if (commit && (cap_addr == DONE_ADDR)) begin
            bus.done       <= 1'b1;
            bus.done_value <= cap_wdata;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (commit) begin
            ram[cap_idx] <= cap_wdata;
        end
    end

endmodule
